// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Arbitrates one serial data bus between NUM_MASTERS masters and
//   NUM_SLAVES slaves. Slaves that have split-read data pending win over
//   masters. Among slaves the lowest index wins. Masters are served
//   round-robin. Every ownership is followed by at least one turnaround
//   cycle, when nobody drives the bus. An owner that holds the bus for
//   TIMEOUT cycles has its ownership revoked.
//
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   m_req        per-master request (level, held for the whole ownership)
//   s_req        per-slave data-return request (level)
//   m_grant      one-hot master grant (registered)
//   s_cmd        one-hot, single-cycle command pulse to the chosen slave
//   bus_util     0 = bus owned, 1 = idle / turnaround (registered)
//   timeout_err  single-cycle pulse when an ownership is revoked
//   dbg_state    current FSM state, for observation only
//
// Handshake: a requester raises its req level and holds it. Ownership
// begins the cycle after the request is sampled in IDLE or TURN, and shows
// as m_grant[i] (master) or as the s_cmd[j] pulse (slave). Ownership ends
// on the edge where the owner's req is sampled low, or on timeout. Requests
// from anyone else are ignored until the next arbitration point.
// ----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_SLAVES-1:0]  s_req,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_SLAVES-1:0]  s_cmd,
  output logic                   bus_util,
  output logic                   timeout_err,
  output logic [2:0]             dbg_state
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MOWN = 3'd1;
  localparam logic [2:0] S_SCMD = 3'd2;
  localparam logic [2:0] S_SOWN = 3'd3;
  localparam logic [2:0] S_TURN = 3'd4;

  // The counter saturates at TIMEOUT. A revoke fires at the end of the
  // TIMEOUT-th owned cycle, which is when the count is TIMEOUT-1.
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT);
  localparam logic [7:0] CNT_LIM = 8'(TIMEOUT - 1);

  logic [2:0]             state_q, state_d;
  logic [MW-1:0]          last_q, last_d;     // last granted master (also the current master owner)
  logic [SW-1:0]          slv_q, slv_d;       // current slave owner
  logic [7:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] m_grant_q, m_grant_d;
  logic [NUM_SLAVES-1:0]  s_cmd_q, s_cmd_d;
  logic                   bus_util_q, bus_util_d;
  logic                   terr_q, terr_d;

  // Round-robin search: candidates are (last+k) mod N for k = 1..N. The
  // loop runs from the farthest candidate down to the nearest, so the
  // nearest requesting master is the one that ends up in m_win.
  logic          m_any;
  logic [MW-1:0] m_win;
  logic [MW:0]   m_cand;

  always_comb begin
    m_any  = 1'b0;
    m_win  = last_q;
    m_cand = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      m_cand = {1'b0, last_q} + (MW+1)'(k);
      if (m_cand >= (MW+1)'(NUM_MASTERS)) m_cand = m_cand - (MW+1)'(NUM_MASTERS);
      if (m_req[m_cand[MW-1:0]]) begin
        m_any = 1'b1;
        m_win = m_cand[MW-1:0];
      end
    end
  end

  // Fixed priority: the lowest requesting slave index wins.
  logic          s_any;
  logic [SW-1:0] s_win;

  always_comb begin
    s_any = |s_req;
    s_win = '0;
    for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
      if (s_req[j]) s_win = SW'(j);
    end
  end

  logic m_own_req;
  logic s_own_req;

  assign m_own_req = m_req[last_q];
  assign s_own_req = s_req[slv_q];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    slv_d   = slv_q;
    terr_d  = 1'b0;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    case (state_q)
      S_IDLE, S_TURN: begin
        cnt_d = '0;
        if (s_any) begin
          state_d = S_SCMD;
          slv_d   = s_win;
        end else if (m_any) begin
          state_d = S_MOWN;
          last_d  = m_win;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MOWN: begin
        // A release in the same cycle as the timeout counts as a normal release.
        if (!m_own_req) begin
          state_d = S_TURN;
        end else if (cnt_q >= CNT_LIM) begin
          state_d = S_TURN;
          terr_d  = 1'b1;
        end
      end
      // The slave's req is not looked at during the command cycle.
      S_SCMD: state_d = S_SOWN;
      S_SOWN: begin
        if (!s_own_req) begin
          state_d = S_TURN;
        end else if (cnt_q >= CNT_LIM) begin
          state_d = S_TURN;
          terr_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All outputs are decoded from the next state, so they change together
  // with the state register.
  always_comb begin
    m_grant_d  = '0;
    s_cmd_d    = '0;
    bus_util_d = 1'b1;
    if (state_d == S_MOWN) m_grant_d[last_d] = 1'b1;
    if (state_d == S_SCMD) s_cmd_d[slv_d] = 1'b1;
    if (state_d == S_MOWN || state_d == S_SCMD || state_d == S_SOWN) bus_util_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      last_q     <= MW'(NUM_MASTERS - 1);
      slv_q      <= '0;
      cnt_q      <= '0;
      m_grant_q  <= '0;
      s_cmd_q    <= '0;
      bus_util_q <= 1'b1;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      slv_q      <= slv_d;
      cnt_q      <= cnt_d;
      m_grant_q  <= m_grant_d;
      s_cmd_q    <= s_cmd_d;
      bus_util_q <= bus_util_d;
      terr_q     <= terr_d;
    end
  end

  assign m_grant     = m_grant_q;
  assign s_cmd       = s_cmd_q;
  assign bus_util    = bus_util_q;
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;

endmodule
